rv32i_pc_gen: RTL and testbench
===============================

RV32I_PC_GEN -- requirements
Module: rv32i_pc_gen

Interface
REQ-001 SHALL provide parameter XLEN, default 32, PC width in bits (legal 32 or 64).
REQ-002 SHALL provide parameter RESET_VEC, default 32'h0000_0000 zero-extended to XLEN, first fetch address.
REQ-003 SHALL provide parameter C_EXT, default 0; 0 = 4-byte target alignment, 1 = 2-byte target alignment.
REQ-004 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset, synchronous and active-high.
REQ-005 SHALL have en in 1, global enable; stall in 1, fetch stage cannot accept a new PC.
REQ-006 SHALL have br_valid in 1 and br_target in XLEN, branch/jump redirect from EX.
REQ-007 SHALL have trap_valid in 1 and trap_target in XLEN, trap/exception redirect.
REQ-008 SHALL have halt_req in 1, request to halt; resume in 1, leave HALT.
REQ-009 SHALL have pc out XLEN, current fetch address; pc_plus4 out XLEN, pc+4; pc_valid out 1, pc is a live fetch request.
REQ-010 SHALL have misalign out 1, misaligned-branch pulse; halted out 1, high in HALT state.

Function
REQ-011 SHALL implement FSM states BOOT, RUN, HALT; all transitions occur on rising clk only when en=1.
REQ-012 With en=0, SHALL hold every register (pc, state, pending, misalign) and ignore all other inputs.
REQ-013 BOOT: pc=RESET_VEC, pc_valid=0; next enabled edge -> RUN, pc unchanged, pc_valid=1.
REQ-014 RUN next-pc priority, highest first: trap_valid, br_valid, pending redirect with stall=0, stall hold, pc+4.
REQ-015 trap_valid SHALL redirect on the next edge regardless of stall, clear the pending redirect, and force target low bits to zero (bits[1:0], or bit[0] when C_EXT=1).
REQ-016 br_valid with stall=1 SHALL hold pc and latch br_target into a one-entry pending register; a later br_valid overwrites it.
REQ-017 Pending redirect SHALL load into pc on the first enabled edge with stall=0, then clear; latency 1 cycle after stall drops.
REQ-018 br_valid with a misaligned target SHALL not redirect or latch; misalign SHALL be 1 for exactly one cycle; pc follows the remaining priorities.
REQ-019 pc+4 SHALL wrap modulo 2^XLEN (2^XLEN-4 -> 0); pc_plus4 SHALL be combinational from pc.
REQ-020 halt_req in RUN SHALL apply any same-edge redirect, then enter HALT: pc held, pc_valid=0, halted=1, pending retained.
REQ-021 HALT: resume -> RUN with pc_valid=1 next cycle; trap_valid -> RUN with pc=trap target (takes priority over resume).
REQ-022 halt_req and resume asserted together in HALT SHALL stay in HALT.

Reset
REQ-023 rst=1 at a rising edge SHALL, regardless of en: pc=RESET_VEC, state=BOOT, pc_valid=0, misalign=0, halted=0, pending cleared.
REQ-024 Reset mid-operation SHALL discard a pending redirect and any in-flight misalign pulse.

Structure
REQ-025 Package rv32i_pkg SHALL hold pc_state_t (PC_BOOT, PC_RUN, PC_HALT), XLEN default, and RESET_VEC default.
REQ-026 Next-PC priority selection SHALL be a combinational sub-module rv32i_pc_next; state, pc and pending registers stay in rv32i_pc_gen.

Verification (XLEN=32, RESET_VEC=0x0000_1000, C_EXT=0)
REQ-027 Reset 1 cycle, en=1 -> pc 0x1000 valid=0, then 0x1000 valid=1, 0x1004, 0x1008; en=0 two cycles -> pc frozen.
REQ-028 stall=1, br_valid pulse target 0x2000, stall held 3 cycles -> pc held; stall=0 -> pc 0x2000 next edge, then 0x2004.
REQ-029 br_valid target 0x3002 -> misalign=1 one cycle, pc continues +4; trap_valid 0x0103 with stall=1 -> pc 0x0100.
REQ-030 pc forced to 0xFFFF_FFF8 via branch -> 0xFFFF_FFFC, 0x0000_0000; pc_plus4 tracks each value.
REQ-031 halt_req in RUN at pc 0x1010 -> halted=1, pc_valid=0, pc 0x1010 held; resume -> pc_valid=1, pc 0x1014 on the following edge.
REQ-032 Pending branch 0x4000 then rst=1 -> pc 0x1000, BOOT; after stall drops, pc never reaches 0x4000.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared types and defaults for the RV32I program-counter generator.
package rv32i_pkg;

  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HALT = 2'd2
  } pc_state_t;

  localparam int unsigned XLEN_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

  // A target is misaligned when its low bits are non-zero for the active
  // instruction granule (2 bytes with compressed support, else 4 bytes).
  function automatic logic misaligned(input logic [1:0] lo, input bit c_ext);
    return c_ext ? lo[0] : (lo != 2'b00);
  endfunction

endpackage

// File: rtl/rv32i_pc_gen_if.sv
// Control/redirect inputs and fetch-address outputs of the PC generator.
interface rv32i_pc_gen_if
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);
  logic            en;
  logic            stall;
  logic            br_valid;
  logic [XLEN-1:0] br_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_target;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            pc_valid;
  logic            misalign;
  logic            halted;

  // PC generator side
  modport master (
    input  en, stall, br_valid, br_target, trap_valid, trap_target,
           halt_req, resume,
    output pc, pc_plus4, pc_valid, misalign, halted
  );

  // Pipeline/control side
  modport slave (
    output en, stall, br_valid, br_target, trap_valid, trap_target,
           halt_req, resume,
    input  pc, pc_plus4, pc_valid, misalign, halted
  );
endinterface

// File: rtl/rv32i_pc_next.sv
// Combinational next-PC / next-state selection for the PC generator.
module rv32i_pc_next
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter bit          C_EXT = 1'b0
) (
  input  pc_state_t       state,
  input  logic [XLEN-1:0] pc,
  input  logic            pend_valid,
  input  logic [XLEN-1:0] pend_target,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            halt_req,
  input  logic            resume,
  output pc_state_t       next_state,
  output logic [XLEN-1:0] next_pc,
  output logic            next_pend_valid,
  output logic [XLEN-1:0] next_pend_target,
  output logic            next_misalign,
  output logic [XLEN-1:0] pc_plus4
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, (C_EXT ? 2'b10 : 2'b00)};
  localparam logic [XLEN-1:0] FOUR       = {{(XLEN-3){1'b0}}, 3'd4};

  logic br_ok;

  assign pc_plus4 = pc + FOUR;
  assign br_ok    = br_valid && !misaligned(br_target[1:0], C_EXT);

  // Priority redirect selection; halting only suppresses sequential advance.
  always_comb begin
    next_state       = state;
    next_pc          = pc;
    next_pend_valid  = pend_valid;
    next_pend_target = pend_target;
    next_misalign    = 1'b0;
    case (state)
      PC_BOOT: next_state = PC_RUN;
      PC_RUN: begin
        if (trap_valid) begin
          next_pc         = trap_target & ALIGN_MASK;
          next_pend_valid = 1'b0;
        end else begin
          next_misalign = br_valid && !br_ok;
          if (br_ok && stall) begin
            next_pend_valid  = 1'b1;
            next_pend_target = br_target;
          end else if (br_ok) begin
            next_pc         = br_target;
            next_pend_valid = 1'b0;
          end else if (pend_valid && !stall) begin
            next_pc         = pend_target;
            next_pend_valid = 1'b0;
          end else if (!stall && !halt_req) begin
            next_pc = pc_plus4;
          end
        end
        if (halt_req) next_state = PC_HALT;
      end
      PC_HALT: begin
        if (trap_valid) begin
          next_state      = PC_RUN;
          next_pc         = trap_target & ALIGN_MASK;
          next_pend_valid = 1'b0;
        end else if (resume && !halt_req) begin
          next_state = PC_RUN;
        end
      end
      default: next_state = PC_BOOT;
    endcase
  end

endmodule

// File: rtl/rv32i_pc_gen.sv
// RV32I fetch program-counter generator: holds state, pc, pending redirect
// and the misalign pulse; selection logic lives in rv32i_pc_next.
module rv32i_pc_gen
  import rv32i_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter bit              C_EXT     = 1'b0
) (
  input logic           clk,
  input logic           rst,
  rv32i_pc_gen_if.master bus
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] pc_plus4;

  rv32i_pc_next #(
    .XLEN  (XLEN),
    .C_EXT (C_EXT)
  ) u_next (
    .state            (state_q),
    .pc               (pc_q),
    .pend_valid       (pend_valid_q),
    .pend_target      (pend_target_q),
    .stall            (bus.stall),
    .br_valid         (bus.br_valid),
    .br_target        (bus.br_target),
    .trap_valid       (bus.trap_valid),
    .trap_target      (bus.trap_target),
    .halt_req         (bus.halt_req),
    .resume           (bus.resume),
    .next_state       (state_d),
    .next_pc          (pc_d),
    .next_pend_valid  (pend_valid_d),
    .next_pend_target (pend_target_d),
    .next_misalign    (misalign_d),
    .pc_plus4         (pc_plus4)
  );

  // State/pc/pending registers: reset wins over enable, en=0 freezes all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PC_BOOT;
      pc_q          <= RESET_VEC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      misalign_q    <= 1'b0;
    end else if (bus.en) begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      misalign_q    <= misalign_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.pc_valid = (state_q == PC_RUN);
  assign bus.halted   = (state_q == PC_HALT);
  assign bus.misalign = misalign_q;

endmodule

// File: tb/tb_rv32i_pc_gen.sv
// Self-checking bench for rv32i_pc_gen: directed vector table plus random
// stimulus against a behavioural reference model.
module tb_rv32i_pc_gen;

  localparam logic [31:0] RV = 32'h0000_1000;

  typedef struct {
    bit          rst, en, stall, brv;
    logic [31:0] brt;
    bit          trv;
    logic [31:0] trt;
    bit          hreq, res;
    logic [31:0] epc;
    bit          evld, ehalt, emis;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  rv32i_pc_gen_if #(.XLEN(32)) bus ();

  rv32i_pc_gen #(
    .XLEN      (32),
    .RESET_VEC (RV),
    .C_EXT     (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: booting/halted flags, pc, a queue holding at most one
  // pending redirect, and the misalign flag.
  bit          m_boot = 1'b1;
  bit          m_halt = 1'b0;
  logic [31:0] m_pc = RV;
  logic [31:0] m_pend[$];
  bit          m_mis = 1'b0;

  function automatic void model_step(input vec_t s);
    bit ok;
    bit redirected;
    if (s.rst) begin
      m_pc = RV; m_boot = 1; m_halt = 0; m_pend.delete(); m_mis = 0;
      return;
    end
    if (!s.en) return;
    m_mis = 0;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      if (s.trv) begin
        m_pc = s.trt - (s.trt % 4); m_pend.delete(); m_halt = 0;
      end else if (s.res && !s.hreq) begin
        m_halt = 0;
      end
    end else begin
      ok = s.brv && (s.brt % 4 == 0);
      redirected = 0;
      if (s.trv) begin
        m_pc = s.trt - (s.trt % 4); m_pend.delete(); redirected = 1;
      end else begin
        if (s.brv && !ok) m_mis = 1;
        if (ok && s.stall) begin
          m_pend.delete(); m_pend.push_back(s.brt);
        end else if (ok) begin
          m_pc = s.brt; m_pend.delete(); redirected = 1;
        end else if (m_pend.size() > 0 && !s.stall) begin
          m_pc = m_pend.pop_front(); redirected = 1;
        end
      end
      if (!redirected && !s.stall && !s.hreq) m_pc = m_pc + 32'd4;
      if (s.hreq) m_halt = 1;
    end
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic vec_t V(input bit r, input bit e, input bit st, input bit bv,
                             input logic [31:0] bt, input bit tv, input logic [31:0] tt,
                             input bit hr, input bit rs, input logic [31:0] pc,
                             input bit vl, input bit hl, input bit ms);
    vec_t v;
    v.rst = r; v.en = e; v.stall = st; v.brv = bv; v.brt = bt; v.trv = tv; v.trt = tt;
    v.hreq = hr; v.res = rs; v.epc = pc; v.evld = vl; v.ehalt = hl; v.emis = ms;
    return v;
  endfunction

  // Drive at negedge, model at posedge, compare at the following negedge.
  task automatic apply(input vec_t v, input string tag);
    rst            = v.rst;
    bus.en         = v.en;
    bus.stall      = v.stall;
    bus.br_valid   = v.brv;
    bus.br_target  = v.brt;
    bus.trap_valid = v.trv;
    bus.trap_target= v.trt;
    bus.halt_req   = v.hreq;
    bus.resume     = v.res;
    @(posedge clk);
    model_step(v);
    @(negedge clk);
    chk({tag, " model_pc"}, bus.pc, m_pc);
    chk({tag, " model_pc_plus4"}, bus.pc_plus4, m_pc + 32'd4);
    chk({tag, " model_pc_valid"}, 32'(bus.pc_valid), 32'(!m_boot && !m_halt));
    chk({tag, " model_halted"}, 32'(bus.halted), 32'(m_halt));
    chk({tag, " model_misalign"}, 32'(bus.misalign), 32'(m_mis));
  endtask

  vec_t vecs[$];
  vec_t rv;

  initial begin
    //            rst en st brv brt           trv trt           hr rs exp_pc        v h m
    vecs.push_back(V(1, 1, 0, 0, 0,            0, 0,            0, 0, 32'h1000,     0,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h1000,     1,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h1004,     1,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h1008,     1,0,0));
    vecs.push_back(V(0, 0, 0, 0, 0,            0, 0,            0, 0, 32'h1008,     1,0,0));
    vecs.push_back(V(0, 0, 0, 1, 32'h7000,     1, 32'h8000,     1, 0, 32'h1008,     1,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h100C,     1,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h1010,     1,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            1, 0, 32'h1010,     0,1,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h1010,     0,1,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            1, 1, 32'h1010,     0,1,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 1, 32'h1010,     1,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h1014,     1,0,0));
    vecs.push_back(V(0, 1, 1, 1, 32'h2000,     0, 0,            0, 0, 32'h1014,     1,0,0));
    vecs.push_back(V(0, 1, 1, 0, 0,            0, 0,            0, 0, 32'h1014,     1,0,0));
    vecs.push_back(V(0, 1, 1, 0, 0,            0, 0,            0, 0, 32'h1014,     1,0,0));
    vecs.push_back(V(0, 1, 1, 0, 0,            0, 0,            0, 0, 32'h1014,     1,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h2000,     1,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h2004,     1,0,0));
    vecs.push_back(V(0, 1, 0, 1, 32'h3002,     0, 0,            0, 0, 32'h2008,     1,0,1));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h200C,     1,0,0));
    vecs.push_back(V(0, 1, 1, 0, 0,            1, 32'h0103,     0, 0, 32'h0100,     1,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h0104,     1,0,0));
    vecs.push_back(V(0, 1, 0, 1, 32'hFFFFFFF8, 0, 0,            0, 0, 32'hFFFFFFF8, 1,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'hFFFFFFFC, 1,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h0000_0000,1,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h0000_0004,1,0,0));
    vecs.push_back(V(0, 1, 1, 1, 32'h4000,     0, 0,            0, 0, 32'h0000_0004,1,0,0));
    vecs.push_back(V(1, 1, 1, 0, 0,            0, 0,            0, 0, 32'h1000,     0,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h1000,     1,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h1004,     1,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h1008,     1,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            1, 0, 32'h1008,     0,1,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            1, 32'h5006,     0, 1, 32'h5004,     1,0,0));
    vecs.push_back(V(0, 1, 0, 0, 0,            0, 0,            0, 0, 32'h5008,     1,0,0));
    vecs.push_back(V(0, 1, 0, 1, 32'h6001,     0, 0,            0, 0, 32'h500C,     1,0,1));
    vecs.push_back(V(1, 0, 0, 0, 0,            0, 0,            0, 0, 32'h1000,     0,0,0));

    bus.en = 1'b0; bus.stall = 1'b0; bus.br_valid = 1'b0; bus.br_target = '0;
    bus.trap_valid = 1'b0; bus.trap_target = '0; bus.halt_req = 1'b0; bus.resume = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      apply(vecs[i], t);
      chk({t, " pc"}, bus.pc, vecs[i].epc);
      chk({t, " pc_plus4"}, bus.pc_plus4, vecs[i].epc + 32'd4);
      chk({t, " pc_valid"}, 32'(bus.pc_valid), 32'(vecs[i].evld));
      chk({t, " halted"}, 32'(bus.halted), 32'(vecs[i].ehalt));
      chk({t, " misalign"}, 32'(bus.misalign), 32'(vecs[i].emis));
    end

    // Random traffic, including near-wrap targets and mid-run resets.
    for (int n = 0; n < 3000; n++) begin
      rv = V(0,0,0,0,0,0,0,0,0,0,0,0,0);
      rv.rst   = ($urandom_range(99) < 2);
      rv.en    = ($urandom_range(99) < 85);
      rv.stall = ($urandom_range(99) < 35);
      rv.brv   = ($urandom_range(99) < 20);
      rv.brt   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                          : ($urandom & 32'h0000_FFFF);
      if ($urandom_range(3) != 0) rv.brt = rv.brt & ~32'h3;
      rv.trv   = ($urandom_range(99) < 5);
      rv.trt   = $urandom;
      rv.hreq  = ($urandom_range(99) < 6);
      rv.res   = ($urandom_range(99) < 30);
      apply(rv, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
